// File: rtl/execute_stage_pipelined.sv
// execute_stage_pipelined
//   Execute stage between the ID/EX register and the memory stage. Computes the
//   ALU result, branch target and destination index for each accepted operation
//   and presents them as a registered EX/MEM beat with a valid/ready handshake.
//   MULT/MULTU run on an iterative shift-add multiplier that writes HI/LO and
//   stalls the stage while it iterates; MFHI/MFLO read the finished product.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             synchronous kill of the output beat and any multiply
//   in_valid/in_ready ID/EX handshake
//   alu_src, alu_op   operand-B select and operation code
//   reg_dst           destination select (1: reg2, 0: reg1)
//   pc_next           incremented PC, base of the branch target
//   data1, data2      register operands (data2 is also the store data)
//   sign_extend       extended immediate
//   reg1, reg2        destination candidates
//   out_ready         MEM stage accepts the beat
//   out_valid ...     registered beat: branch_pc, zero, alu_result, data2_out,
//                     dst, illegal_op
//   mul_busy          multiplier iterating
module execute_stage_pipelined #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 7,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_src,
  input  logic [5:0]        alu_op,
  input  logic              reg_dst,
  input  logic [PC_W-1:0]   pc_next,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] sign_extend,
  input  logic [REG_W-1:0]  reg1,
  input  logic [REG_W-1:0]  reg2,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   branch_pc,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] data2_out,
  output logic [REG_W-1:0]  dst,
  output logic              mul_busy,
  output logic              illegal_op
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_XOR   = 6'b000100;
  localparam logic [5:0] OP_NOR   = 6'b000101;
  localparam logic [5:0] OP_SLT   = 6'b000110;
  localparam logic [5:0] OP_SLTU  = 6'b000111;
  localparam logic [5:0] OP_SLL   = 6'b001000;
  localparam logic [5:0] OP_SRL   = 6'b001001;
  localparam logic [5:0] OP_SRA   = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001011;
  localparam logic [5:0] OP_MULT  = 6'b010000;
  localparam logic [5:0] OP_MULTU = 6'b010001;
  localparam logic [5:0] OP_MFHI  = 6'b010010;
  localparam logic [5:0] OP_MFLO  = 6'b010011;

  typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_t;

  mul_state_t state, state_next;

  logic [DATA_W-1:0]   op_b;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_illegal;
  logic                is_mult;
  logic                accept;
  logic                load_beat;
  logic                start_mul;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   hi, lo;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_sum;
  logic [CNT_W-1:0]    cnt;
  logic                negate;
  logic                mul_last;

  assign op_b  = alu_src ? sign_extend : data2;
  assign shamt = op_b[SH_W-1:0];

  assign is_mult   = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign mul_busy  = (state == MUL_RUN);
  // A held beat blocks new work unless MEM takes it this same cycle.
  assign in_ready  = !mul_busy && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign load_beat = accept && !is_mult;
  assign start_mul = accept && is_mult;

  // The multiplier works on magnitudes; the sign is restored at the end.
  assign a_neg = (alu_op == OP_MULT) && data1[DATA_W-1];
  assign b_neg = (alu_op == OP_MULT) && op_b[DATA_W-1];
  assign a_mag = a_neg ? -data1 : data1;
  assign b_mag = b_neg ? -op_b : op_b;

  assign prod_sum = prod + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_W'(DATA_W - 1));

  // ALU result. MULT/MULTU are defined ops but produce no beat, so their
  // result value is irrelevant.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_op)
      OP_ADD:   alu_res = data1 + op_b;
      OP_SUB:   alu_res = data1 - op_b;
      OP_AND:   alu_res = data1 & op_b;
      OP_OR:    alu_res = data1 | op_b;
      OP_XOR:   alu_res = data1 ^ op_b;
      OP_NOR:   alu_res = ~(data1 | op_b);
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(data1) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (data1 < op_b)};
      OP_SLL:   alu_res = data1 << shamt;
      OP_SRL:   alu_res = data1 >> shamt;
      OP_SRA:   alu_res = $signed(data1) >>> shamt;
      OP_LUI:   alu_res = op_b << (DATA_W / 2);
      OP_MULT,
      OP_MULTU: alu_res = '0;
      OP_MFHI:  alu_res = hi;
      OP_MFLO:  alu_res = lo;
      default:  alu_illegal = 1'b1;
    endcase
  end

  // Multiplier control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_next;
  end

  // Runs for exactly DATA_W cycles after a MULT/MULTU accept; flush aborts.
  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (start_mul) state_next = MUL_RUN;
      MUL_RUN:  if (flush || mul_last) state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // Shift-add datapath. The last iteration folds its partial product straight
  // into HI/LO; an aborted multiply never touches HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      negate <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (start_mul) begin
      mcand  <= {{DATA_W{1'b0}}, a_mag};
      mplier <= b_mag;
      prod   <= '0;
      cnt    <= '0;
      negate <= a_neg ^ b_neg;
    end else if (mul_busy && !flush) begin
      prod   <= prod_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (mul_last) {hi, lo} <= negate ? -prod_sum : prod_sum;
    end
  end

  // EX/MEM output register. A new beat wins over both flush (never concurrent,
  // since flush blocks accept) and the out_ready drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      branch_pc  <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      data2_out  <= '0;
      dst        <= '0;
      illegal_op <= 1'b0;
    end else if (load_beat) begin
      out_valid  <= 1'b1;
      branch_pc  <= pc_next + sign_extend[PC_W-1:0];
      zero       <= (alu_res == '0);
      alu_result <= alu_res;
      data2_out  <= data2;
      dst        <= reg_dst ? reg2 : reg1;
      illegal_op <= alu_illegal;
    end else if (flush) begin
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// tb_execute_stage_pipelined
//   Directed bench for execute_stage_pipelined with default parameters
//   (DATA_W=32, PC_W=7, REG_W=5). Each task drives one scenario and checks
//   hand-computed expectations at 1 ns after the rising edge.
module tb_execute_stage_pipelined;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_XOR   = 6'b000100;
  localparam logic [5:0] OP_NOR   = 6'b000101;
  localparam logic [5:0] OP_SLT   = 6'b000110;
  localparam logic [5:0] OP_SLTU  = 6'b000111;
  localparam logic [5:0] OP_SLL   = 6'b001000;
  localparam logic [5:0] OP_SRL   = 6'b001001;
  localparam logic [5:0] OP_SRA   = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001011;
  localparam logic [5:0] OP_MULT  = 6'b010000;
  localparam logic [5:0] OP_MULTU = 6'b010001;
  localparam logic [5:0] OP_MFHI  = 6'b010010;
  localparam logic [5:0] OP_MFLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        alu_src;
  logic [5:0]  alu_op;
  logic        reg_dst;
  logic [6:0]  pc_next;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] sign_extend;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  branch_pc;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] data2_out;
  logic [4:0]  dst;
  logic        mul_busy;
  logic        illegal_op;

  int vectors = 0;
  int miscompares = 0;

  // Shift/compare table: op, A, B (via data2), expected result.
  logic [5:0]  t_op  [9] = '{OP_SLL, OP_SRL, OP_SLT, OP_SLTU, OP_LUI,
                             OP_NOR, OP_OR, OP_SRA, OP_SUB};
  logic [31:0] t_a   [9] = '{32'h1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                             32'h0, 32'hF0, 32'h80000000, 32'h0};
  logic [31:0] t_b   [9] = '{32'd4, 32'd4, 32'h1, 32'h1, 32'h1234,
                             32'h0, 32'h0F, 32'd33, 32'h1};
  logic [31:0] t_exp [9] = '{32'h10, 32'h08000000, 32'h1, 32'h0, 32'h12340000,
                             32'hFFFFFFFF, 32'hFF, 32'hC0000000, 32'hFFFFFFFF};

  execute_stage_pipelined dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
    .pc_next(pc_next), .data1(data1), .data2(data2),
    .sign_extend(sign_extend), .reg1(reg1), .reg2(reg2),
    .out_ready(out_ready), .out_valid(out_valid), .branch_pc(branch_pc),
    .zero(zero), .alu_result(alu_result), .data2_out(data2_out),
    .dst(dst), .mul_busy(mul_busy), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] imm, input logic [6:0] pc,
                       input logic rd, input logic [4:0] r1, input logic [4:0] r2);
    alu_op      = op;
    data1       = a;
    data2       = b;
    alu_src     = src;
    sign_extend = imm;
    pc_next     = pc;
    reg_dst     = rd;
    reg1        = r1;
    reg2        = r2;
    in_valid    = 1'b1;
  endtask

  // Counts sampled cycles with mul_busy high, bounded so a stuck multiplier
  // still reaches the summary.
  task automatic wait_mul(output int busy_cycles);
    busy_cycles = 0;
    while (mul_busy && busy_cycles < 100) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (alu_result !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_alu_result got %h want 0", alu_result); end
    vectors++; if (mul_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mul_busy got %b want 0", mul_busy); end
    vectors++; if ({branch_pc, dst, zero, illegal_op} !== 14'h0) begin miscompares++; $display("[TB] FAIL reset_misc got %h want 0", {branch_pc, dst, zero, illegal_op}); end
    vectors++; if (data2_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data2_out got %h want 0", data2_out); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_add;
    drive(OP_ADD, 32'd10, 32'd6, 1'b0, 32'd4, 7'd1, 1'b1, 5'd7, 5'd3);
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_out_valid got %b want 1", out_valid); end
    vectors++; if (alu_result !== 32'd16) begin miscompares++; $display("[TB] FAIL add_result got %h want 10", alu_result); end
    vectors++; if (branch_pc !== 7'd5) begin miscompares++; $display("[TB] FAIL add_branch_pc got %0d want 5", branch_pc); end
    vectors++; if (dst !== 5'd3) begin miscompares++; $display("[TB] FAIL add_dst got %0d want 3", dst); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("[TB] FAIL add_zero got %b want 0", zero); end
    vectors++; if (data2_out !== 32'd6) begin miscompares++; $display("[TB] FAIL add_data2_out got %h want 6", data2_out); end
    vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("[TB] FAIL add_illegal got %b want 0", illegal_op); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(OP_AND, 32'd10, 32'd6, 1'b0, 32'd0, 7'd0, 1'b0, 5'd9, 5'd1);
    step();
    // Queue a SUB while the AND beat is stalled.
    drive(OP_SUB, 32'd4, 32'd4, 1'b0, 32'd0, 7'd0, 1'b0, 5'd2, 5'd1);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (alu_result !== 32'd2 || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_hold%0d got %h/%b want 2/1", i, alu_result, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (alu_result !== 32'd0 || zero !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_sub got %h/%b want 0/1", alu_result, zero); end
    vectors++; if (out_valid !== 1'b1 || dst !== 5'd2) begin miscompares++; $display("[TB] FAIL bp_replace got %b/%0d want 1/2", out_valid, dst); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_mult;
    int n;
    drive(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (mul_busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_start got busy %b ready %b want 1/0", mul_busy, in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_no_beat got %b want 0", out_valid); end
    wait_mul(n);
    vectors++; if (n !== 32) begin miscompares++; $display("[TB] FAIL mult_busy_len got %0d want 32", n); end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (alu_result !== 32'hFFFFFFF1 || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_lo got %h/%b want fffffff1/1", alu_result, out_valid); end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (alu_result !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL mult_hi got %h want ffffffff", alu_result); end
    drive(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    wait_mul(n);
    vectors++; if (n !== 32) begin miscompares++; $display("[TB] FAIL multu_busy_len got %0d want 32", n); end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (alu_result !== 32'h1) begin miscompares++; $display("[TB] FAIL multu_hi got %h want 1", alu_result); end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (alu_result !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL multu_lo got %h want fffffffe", alu_result); end
    step();
  endtask

  task automatic test_shifts;
    drive(OP_SRA, 32'h80000000, 32'd0, 1'b1, 32'd4, 7'd127, 1'b0, 5'd4, 5'd8);
    step();
    vectors++; if (alu_result !== 32'hF8000000) begin miscompares++; $display("[TB] FAIL sra_imm got %h want f8000000", alu_result); end
    vectors++; if (branch_pc !== 7'd3 || data2_out !== 32'd0) begin miscompares++; $display("[TB] FAIL sra_bpc_d2 got %0d/%h want 3/0", branch_pc, data2_out); end
    for (int i = 0; i < 9; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 1'b0, 32'd1, 7'd127, 1'b0, 5'(i), 5'd31);
      step();
      vectors++; if (alu_result !== t_exp[i] || zero !== (t_exp[i] == 32'd0)) begin miscompares++; $display("[TB] FAIL table%0d got %h/%b want %h", i, alu_result, zero, t_exp[i]); end
      vectors++; if (branch_pc !== 7'd0 || dst !== 5'(i)) begin miscompares++; $display("[TB] FAIL table%0d_bpc_dst got %0d/%0d want 0/%0d", i, branch_pc, dst, i); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush;
    drive(OP_MULT, 32'd7, 32'd9, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    vectors++; if (mul_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_mul_pre got %b want 1", mul_busy); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (mul_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_mul_abort got %b want 0", mul_busy); end
    drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (alu_result !== 32'h1) begin miscompares++; $display("[TB] FAIL flush_hi_kept got %h want 1", alu_result); end
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (alu_result !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL flush_lo_kept got %h want fffffffe", alu_result); end
    // Flush of a stalled beat with a concurrent request that must be refused.
    out_ready = 1'b0;
    drive(OP_ADD, 32'd2, 32'd3, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    drive(OP_XOR, 32'd1, 32'd2, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    flush = 1'b1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_beat got %b want 0", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_accept got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal;
    out_ready = 1'b0;
    drive(6'b111111, 32'd5, 32'd5, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (illegal_op !== 1'b1 || alu_result !== 32'h0) begin miscompares++; $display("[TB] FAIL illegal_beat got %b/%h want 1/0", illegal_op, alu_result); end
    vectors++; if (zero !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_zero_valid got %b/%b want 1/1", zero, out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_flush got %b want 0", illegal_op); end
    out_ready = 1'b1;
    drive(6'b010100, 32'd5, 32'd5, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++; if (illegal_op !== 1'b1 || alu_result !== 32'h0) begin miscompares++; $display("[TB] FAIL illegal_gap got %b/%h want 1/0", illegal_op, alu_result); end
    drive(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (illegal_op !== 1'b0 || alu_result !== 32'd2) begin miscompares++; $display("[TB] FAIL illegal_clear got %b/%h want 0/2", illegal_op, alu_result); end
    step();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(OP_ADD, 32'd5, 32'd5, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || alu_result !== 32'h0) begin miscompares++; $display("[TB] FAIL areset_beat got %b/%h want 0/0", out_valid, alu_result); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    drive(OP_MULT, 32'd3, 32'd3, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mul_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_mul got %b want 0", mul_busy); end
    @(negedge clk) rst_n = 1'b1;
    step();
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    vectors++; if (alu_result !== 32'h0 || zero !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_lo got %h/%b want 0/1", alu_result, zero); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_src = 1'b0;
    alu_op = 6'd0;
    reg_dst = 1'b0;
    pc_next = 7'd0;
    data1 = 32'd0;
    data2 = 32'd0;
    sign_extend = 32'd0;
    reg1 = 5'd0;
    reg2 = 5'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_mult();
    test_shifts();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage_pipelined.md
Name: execute_stage_pipelined

Overview:
Parametrised successor to the combinational execute stage of the pipeline.
- Adds a registered EX/MEM output stage with a valid/ready handshake, synchronous flush, shift ops and SLT.
- Adds an iterative HI/LO multiplier that stalls the stage while busy.
- Sits between the ID/EX register and the memory stage.

Parameters:
DATA_W, 32, datapath width; power of two, >= 8
PC_W, 7, width of pc_next/branch_pc
REG_W, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill: drops the output beat and aborts the multiply
in_valid  in  1  ID/EX presents an operation
in_ready  out  1  stage accepts the operation this cycle
alu_src  in  1  1: operand B = sign_extend, 0: operand B = data2
alu_op  in  6  operation code (see Behaviour)
reg_dst  in  1  1: dst = reg2, 0: dst = reg1
pc_next  in  PC_W  incremented PC
data1  in  DATA_W  operand A
data2  in  DATA_W  register operand B / store data
sign_extend  in  DATA_W  extended immediate
reg1  in  REG_W  destination candidate 0
reg2  in  REG_W  destination candidate 1
out_ready  in  1  MEM stage accepts the beat
out_valid  out  1  registered beat valid
branch_pc  out  PC_W  registered branch target
zero  out  1  registered (alu_result == 0)
alu_result  out  DATA_W  registered result
data2_out  out  DATA_W  registered data2 passthrough
dst  out  REG_W  registered destination index
mul_busy  out  1  multiplier iterating
illegal_op  out  1  registered; beat carried an undefined alu_op

Behaviour:
- Reset (rst_n low, async): all outputs 0, HI = LO = 0, multiplier idle. Reset mid-multiply discards it.
- Handshake:
  - accept = in_valid && in_ready.
  - in_ready = !mul_busy && !flush && (!out_valid || out_ready).
  - Output registers load on accept of a non-MULT op (1-cycle latency); out_valid rises the next cycle.
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid falls after out_ready when no new beat loads.
- Operand B = alu_src ? sign_extend : data2. shamt = B[log2(DATA_W)-1:0].
- alu_op encoding:
  - 000000 ADD; 000001 SUB; 000010 AND; 000011 OR; 000100 XOR; 000101 NOR.
  - 000110 SLT (signed, result 1/0); 000111 SLTU.
  - 001000 SLL A<<shamt; 001001 SRL; 001010 SRA (arithmetic).
  - 001011 LUI: B << DATA_W/2.
  - 010000 MULT (signed); 010001 MULTU.
  - 010010 MFHI; 010011 MFLO.
- Undefined alu_op: beat loads with alu_result = 0, zero = 1, illegal_op = 1. illegal_op is 0 on every defined op.
- ADD/SUB wrap modulo 2^DATA_W; no overflow trap.
- branch_pc = pc_next + sign_extend[PC_W-1:0], wraps modulo 2^PC_W; computed for every op.
- data2_out = data2 unmodified (not operand B).
- dst = reg_dst ? reg2 : reg1.
- MULT/MULTU:
  - Accept produces no output beat. mul_busy is high the cycle after accept, for exactly DATA_W cycles.
  - Radix-2 shift-add on magnitudes; signed product negated in the final cycle if operand signs differ.
  - {HI,LO} (2*DATA_W bits) written on the cycle mul_busy falls; in_ready low throughout.
- MFHI/MFLO read current HI/LO. They cannot issue during a multiply (in_ready low), so they always see the completed product.
- Flush:
  - Next edge clears out_valid and illegal_op. Other output registers may keep stale data.
  - Aborts an in-flight multiply: mul_busy falls, HI/LO unchanged.
  - in_ready is 0 during flush, so a concurrent in_valid is not accepted.
- Simultaneous out_ready handshake and new accept: the new beat replaces the old in the same edge; out_valid stays 1.

Test Plan:
- Reset with rst_n low mid-cycle -> all outputs 0 immediately; mul_busy 0.
- ADD: data1=10, data2=6, alu_src=0, op=000000, pc_next=1, sign_extend=4, reg_dst=1, reg2=3 -> next cycle out_valid=1, alu_result=16, branch_pc=5, dst=3, zero=0, data2_out=6.
- Backpressure: AND 10&6 with out_ready=0 for 3 cycles -> alu_result=2 held and in_ready=0; with out_ready=1 and a queued SUB 4-4 -> alu_result=0, zero=1 next cycle.
- MULT: data1=-3, data2=5 -> mul_busy high 32 cycles, no beat. Then MFLO gives 0xFFFFFFF1 and MFHI gives 0xFFFFFFFF. Also check the MULTU wrap case 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- Shifts/SLT: SRA 0x80000000 by B=4 -> 0xF8000000. SLT -1<1 -> 1. SLTU -1<1 -> 0. pc_next=127, sign_extend=1 -> branch_pc=0.
- Flush at cycle 10 of MULT -> mul_busy 0 next cycle, HI/LO keep previous values. Undefined op 111111 -> illegal_op=1, alu_result=0.
